minterm_sweep_checker: RTL
==========================

MINTERM_SWEEP_CHECKER -- requirements
Module: minterm_sweep_checker

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter MINTERMS, default 16'h230D, giving the expected output per input index, where bit i is f(i), i.e. Sm(0,2,3,8,9,13).
REQ-003 The block SHALL have parameter SETTLE, default 2, giving the settle cycles per vector; legal range 1..15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle sweep request, honoured only in IDLE.
REQ-007 dut_s  input  1  output of the combinational function under test.
REQ-008 vec  output  4  drive to the function under test: vec[3]=x, vec[2]=y, vec[1]=w, vec[0]=z.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 pass  output  1  high when the last sweep had zero mismatches; valid from done until the next start.
REQ-012 err_count  output  5  mismatches in the last or current sweep, range 0..16.
REQ-013 first_err  output  4  index of the first mismatching vector; valid only when err_count != 0.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE_WAIT, SAMPLE and FINISH.
REQ-015 In IDLE with start=1 the block SHALL, at the next edge, set vec=0, clear err_count, clear first_err, clear pass, load the settle counter with SETTLE-1, and enter SETTLE_WAIT.
REQ-016 In SETTLE_WAIT the block SHALL decrement the settle counter each cycle and enter SAMPLE when it reaches 0, so that vec is stable for exactly SETTLE cycles before sampling.
REQ-017 SAMPLE SHALL last one cycle, during which dut_s is compared to MINTERMS[vec].
REQ-018 On a mismatch in SAMPLE the block SHALL increment err_count; if err_count was 0, it SHALL also capture first_err=vec.
REQ-019 In SAMPLE with vec<15 the block SHALL increment vec, reload the settle counter, and return to SETTLE_WAIT.
REQ-020 In SAMPLE with vec=15 the block SHALL enter FINISH, with no wrap of vec.
REQ-021 FINISH SHALL last one cycle: done=1, pass=(err_count==0) registered, then the FSM returns to IDLE.
REQ-022 Each vector SHALL occupy SETTLE+1 cycles; with start sampled at edge k, done SHALL be high in the cycle after edge k+1+16*(SETTLE+1).
REQ-023 busy SHALL be 1 in SETTLE_WAIT, SAMPLE and FINISH, and 0 in IDLE.
REQ-024 start while busy SHALL be ignored, with no restart and no effect on counters.
REQ-025 start in the same cycle as FINISH SHALL be ignored; a new sweep needs start in IDLE.
REQ-026 In IDLE, vec SHALL hold its last value (15 after a sweep), and err_count, first_err and pass SHALL hold until the next accepted start.
REQ-027 dut_s SHALL be sampled only in SAMPLE; its value in other states SHALL be ignored.
REQ-028 err_count SHALL saturate by construction at 16 (16 samples per sweep), and its 5-bit width SHALL never overflow.

Reset
REQ-029 When rst=1 at a clock edge the block SHALL enter IDLE and set vec=0, busy=0, done=0, pass=0, err_count=0, first_err=0, and settle counter=0.
REQ-030 rst SHALL take priority over start and abort any sweep in progress without asserting done.
REQ-031 A start in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, SETTLE_WAIT=1, SAMPLE=2, FINISH=3), the default MINTERMS constant 16'h230D, and the vector width 4.
REQ-033 The 4-bit settle down-counter with load and zero flag SHALL be one sub-module, settle_timer; the rest is a single FSM with datapath.

Verification
REQ-034 Correct DUT: reset, start=1 for 1 cycle, dut_s=MINTERMS[vec] -> vec sweeps 0..15, done pulses at cycle 1+16*3=49 after the start edge, pass=1, err_count=0.
REQ-035 Faulty DUT forcing dut_s=0 -> err_count=6, first_err=0, pass=0.
REQ-036 Faulty DUT inverting f at index 13 only -> err_count=1, first_err=13, pass=0.
REQ-037 start pulsed again at vec=5 mid-sweep -> no restart, done at the original cycle, results unchanged.
REQ-038 rst asserted at vec=7 -> the next cycle is IDLE with vec=0, busy=0, no done pulse; a following start gives a full correct sweep.
REQ-039 SETTLE=1 with a DUT model of 1-cycle latency -> pass=1, done at cycle 33; the same model with SETTLE=0 is illegal and is not exercised.

Source files
------------

// File: rtl/minterm_sweep_checker_pkg.sv
// Shared constants and FSM encoding for the minterm sweep checker.
package minterm_sweep_checker_pkg;

    localparam int unsigned VEC_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 5;

    localparam logic [15:0]      DEFAULT_MINTERMS = 16'h230D;
    localparam logic [VEC_W-1:0] LAST_VEC         = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SETTLE_WAIT = 2'd1,
        ST_SAMPLE      = 2'd2,
        ST_FINISH      = 2'd3
    } state_e;

endpackage

// File: rtl/minterm_sweep_checker_if.sv
// Control, stimulus and result signals between the checker and its user.
interface minterm_sweep_checker_if;
    import minterm_sweep_checker_pkg::*;

    logic             start;
    logic             dut_s;
    logic [VEC_W-1:0] vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [VEC_W-1:0] first_err;

    modport master (
        output start, dut_s,
        input  vec, busy, done, pass, err_count, first_err
    );

    modport slave (
        input  start, dut_s,
        output vec, busy, done, pass, err_count, first_err
    );

endinterface

// File: rtl/minterm_sweep_checker_settle_timer.sv
// Loadable settle down-counter; holds at zero and flags it.
module settle_timer
    import minterm_sweep_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Sweeps all 16 input vectors of a 4-input function and compares the
// sampled response against the expected truth table.
module minterm_sweep_checker
    import minterm_sweep_checker_pkg::*;
#(
    parameter logic [15:0] MINTERMS = DEFAULT_MINTERMS,
    parameter int unsigned SETTLE   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    minterm_sweep_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    state_e           r_state, w_state_nxt;
    logic [VEC_W-1:0] r_vec, w_vec_nxt;
    logic [ERR_W-1:0] r_err, w_err_nxt;
    logic [VEC_W-1:0] r_first, w_first_nxt;
    logic             r_pass, w_pass_nxt;
    logic             r_done, w_done_nxt;
    logic             r_busy;
    logic             w_load, w_dec, w_zero, w_mismatch;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_dec),
        .o_zero_c   (w_zero)
    );

    assign w_mismatch = (bus.dut_s != MINTERMS[r_vec]);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_err   <= w_err_nxt;
            r_first <= w_first_nxt;
            r_pass  <= w_pass_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and datapath updates; start outside IDLE is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_err_nxt   = r_err;
        w_first_nxt = r_first;
        w_pass_nxt  = r_pass;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_vec_nxt   = '0;
                    w_err_nxt   = '0;
                    w_first_nxt = '0;
                    w_pass_nxt  = 1'b0;
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETTLE_WAIT;
                end
            end
            ST_SETTLE_WAIT: begin
                if (w_zero) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + ERR_W'(1);
                    if (r_err == '0) begin
                        w_first_nxt = r_vec;
                    end
                end
                if (r_vec != LAST_VEC) begin
                    w_vec_nxt   = r_vec + VEC_W'(1);
                    w_load      = 1'b1;
                    w_state_nxt = ST_SETTLE_WAIT;
                end else begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_done_nxt  = 1'b1;
                w_pass_nxt  = (r_err == '0);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.vec       = r_vec;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.first_err = r_first;

endmodule
